// File: rtl/writeback_unit_pkg.sv
// Shared constants and types for the register-file writeback path.
package writeback_unit_pkg;

    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 32;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LD  = 1'b1
    } grant_e;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Result FIFO with wrap-bit pointers and a youngest-match bypass search.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  wb_entry_t                    i_entry,
    input  logic                         i_pop,
    output wb_entry_t                    o_head,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    input  logic [WB_ADDR_W-1:0]         i_byp_reg1,
    input  logic [WB_ADDR_W-1:0]         i_byp_reg2,
    output logic                         o_byp_hit1,
    output logic                         o_byp_hit2,
    output logic [WB_DATA_W-1:0]         o_byp_data1,
    output logic [WB_DATA_W-1:0]         o_byp_data2
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;

    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] w_count;
    wb_entry_t       r_mem [DEPTH];

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_count = w_count;
    assign o_empty = (w_count == '0);
    assign o_full  = (w_count == PtrW'(DEPTH));
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr[IdxW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[IdxW-1:0]] <= i_entry;
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        logic [IdxW-1:0] w_idx;
        w_idx       = '0;
        o_byp_hit1  = 1'b0;
        o_byp_hit2  = 1'b0;
        o_byp_data1 = '0;
        o_byp_data2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr[IdxW-1:0] + IdxW'(i);
            if (PtrW'(i) < w_count) begin
                if (i_byp_reg1 != '0 && r_mem[w_idx].rd == i_byp_reg1) begin
                    o_byp_hit1  = 1'b1;
                    o_byp_data1 = r_mem[w_idx].data;
                end
                if (i_byp_reg2 != '0 && r_mem[w_idx].rd == i_byp_reg2) begin
                    o_byp_hit2  = 1'b1;
                    o_byp_data2 = r_mem[w_idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// ALU/load result arbiter feeding the register-file write port through wb_fifo.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_reg,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [ADDR_W-1:0]          ld_reg,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       rf_busy,
    output logic                       regWrite,
    output logic [ADDR_W-1:0]          writeReg,
    output logic [DATA_W-1:0]          writeData,
    input  logic [ADDR_W-1:0]          byp_reg1,
    input  logic [ADDR_W-1:0]          byp_reg2,
    output logic                       byp_hit1,
    output logic                       byp_hit2,
    output logic [DATA_W-1:0]          byp_data1,
    output logic [DATA_W-1:0]          byp_data2,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    grant_e    r_last_grant;
    logic      w_full;
    logic      w_empty;
    logic      w_alu_fire;
    logic      w_ld_fire;
    logic      w_push;
    wb_entry_t w_entry;
    wb_entry_t w_head;

    // Full blocks both sources even when the head pops this cycle.
    assign alu_ready  = !w_full && (!ld_valid || r_last_grant == GRANT_LD);
    assign ld_ready   = !w_full && (!alu_valid || r_last_grant == GRANT_ALU);
    assign w_alu_fire = alu_valid && alu_ready;
    assign w_ld_fire  = ld_valid && ld_ready;

    // r0 results finish the handshake but never reach the FIFO.
    assign w_push  = (w_alu_fire && alu_reg != '0) || (w_ld_fire && ld_reg != '0);
    assign w_entry = w_ld_fire ? '{rd: ld_reg, data: ld_data} : '{rd: alu_reg, data: alu_data};

    assign regWrite  = !w_empty && !rf_busy;
    assign writeReg  = w_head.rd;
    assign writeData = w_head.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_ALU;
        end else if (w_ld_fire) begin
            r_last_grant <= GRANT_LD;
        end else if (w_alu_fire) begin
            r_last_grant <= GRANT_ALU;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_entry     (w_entry),
        .i_pop       (regWrite),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_count     (pending),
        .i_byp_reg1  (byp_reg1),
        .i_byp_reg2  (byp_reg2),
        .o_byp_hit1  (byp_hit1),
        .o_byp_hit2  (byp_hit2),
        .o_byp_data1 (byp_data1),
        .o_byp_data2 (byp_data2)
    );

endmodule

// File: tb/tb_writeback_unit.sv
// Directed vector table plus hand sequences for back-pressure, bypass and reset.
module tb_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_reg;
    logic [31:0] ld_data;
    logic        rf_busy;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  byp_reg1;
    logic [4:0]  byp_reg2;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;
    logic [2:0]  pending;

    int checks;
    int errors;

    writeback_unit #(
        .DEPTH  (4),
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_reg    (ld_reg),
        .ld_data   (ld_data),
        .rf_busy   (rf_busy),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .byp_reg1  (byp_reg1),
        .byp_reg2  (byp_reg2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  areg;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lreg;
        logic [31:0] ldata;
        logic        busy;
        logic [4:0]  b1;
        logic [4:0]  b2;
        logic        e_ar;
        logic        e_lr;
        logic        e_rw;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic [2:0]  e_pend;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_reg   = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_reg    = '0;
        ld_data   = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        rf_busy  = 1'b0;
        byp_reg1 = 5'd5;
        byp_reg2 = 5'd0;

        //                av areg adata         lv lreg ldata     busy b1 b2  ar lr rw wreg wdata        pend h1 d1           h2 d2
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    1'b0, 5'd5, 5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd5, 5'd0,  1'b1, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 3'd1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd5, 5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[4]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,   1'b0, 5'd4, 5'd3,  1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[5]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,   1'b0, 5'd4, 5'd3,  1'b1, 1'b0, 1'b1, 5'd4,  32'h22,       3'd1, 1'b1, 32'h22,       1'b0, 32'h0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd4, 5'd3,  1'b1, 1'b1, 1'b1, 5'd3,  32'h11,       3'd1, 1'b0, 32'h0,        1'b1, 32'h11};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd4, 5'd3,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFF, 1'b0, 5'd0, 5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[10] = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd10, 32'hAA,   1'b0, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'hAA,   1'b0, 5'd9, 5'd10, 1'b0, 1'b1, 1'b1, 5'd9,  32'h99,       3'd1, 1'b1, 32'h99,       1'b0, 32'h0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 5'd10, 32'hAA,       3'd1, 1'b0, 32'h0,        1'b1, 32'hAA};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};

        // Reset state.
        #1;
        chk("rst_regWrite",  32'(regWrite),  32'd0);
        chk("rst_writeReg",  32'(writeReg),  32'd0);
        chk("rst_writeData", writeData,      32'd0);
        chk("rst_pending",   32'(pending),   32'd0);
        chk("rst_hit1",      32'(byp_hit1),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            alu_valid = vecs[i].av;
            alu_reg   = vecs[i].areg;
            alu_data  = vecs[i].adata;
            ld_valid  = vecs[i].lv;
            ld_reg    = vecs[i].lreg;
            ld_data   = vecs[i].ldata;
            rf_busy   = vecs[i].busy;
            byp_reg1  = vecs[i].b1;
            byp_reg2  = vecs[i].b2;
            #1;
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
            chk($sformatf("v%0d_ld_ready", i),  32'(ld_ready),  32'(vecs[i].e_lr));
            chk($sformatf("v%0d_regWrite", i),  32'(regWrite),  32'(vecs[i].e_rw));
            chk($sformatf("v%0d_writeReg", i),  32'(writeReg),  32'(vecs[i].e_wreg));
            chk($sformatf("v%0d_writeData", i), writeData,      vecs[i].e_wdata);
            chk($sformatf("v%0d_pending", i),   32'(pending),   32'(vecs[i].e_pend));
            chk($sformatf("v%0d_hit1", i),      32'(byp_hit1),  32'(vecs[i].e_h1));
            chk($sformatf("v%0d_data1", i),     byp_data1,      vecs[i].e_d1);
            chk($sformatf("v%0d_hit2", i),      32'(byp_hit2),  32'(vecs[i].e_h2));
            chk($sformatf("v%0d_data2", i),     byp_data2,      vecs[i].e_d2);
            tick();
        end

        // Back-pressure: fill while the write port is busy.
        idle_inputs();
        byp_reg1 = 5'd0;
        byp_reg2 = 5'd0;
        rf_busy  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            alu_valid = 1'b1;
            alu_reg   = 5'(k);
            alu_data  = 32'h100 + 32'(k);
            #1;
            chk($sformatf("bp_push%0d_ready", k),   32'(alu_ready), 32'd1);
            chk($sformatf("bp_push%0d_pending", k), 32'(pending),   32'(k - 1));
            chk($sformatf("bp_push%0d_regWrite", k), 32'(regWrite), 32'd0);
            tick();
        end
        alu_reg  = 5'd20;
        alu_data = 32'h200;
        byp_reg1 = 5'd2;
        #1;
        chk("bp_full_alu_ready", 32'(alu_ready), 32'd0);
        chk("bp_full_ld_ready",  32'(ld_ready),  32'd0);
        chk("bp_full_pending",   32'(pending),   32'd4);
        chk("bp_full_hit1",      32'(byp_hit1),  32'd1);
        chk("bp_full_data1",     byp_data1,      32'h102);
        // Pop while full must not let a new result in.
        rf_busy = 1'b0;
        #1;
        chk("bp_nopass_ready",    32'(alu_ready), 32'd0);
        chk("bp_nopass_regWrite", 32'(regWrite),  32'd1);
        tick();
        alu_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            #1;
            chk($sformatf("bp_drain%0d_regWrite", k), 32'(regWrite), 32'd1);
            chk($sformatf("bp_drain%0d_reg", k),      32'(writeReg), 32'(k));
            chk($sformatf("bp_drain%0d_data", k),     writeData,     32'h100 + 32'(k));
            chk($sformatf("bp_drain%0d_pending", k),  32'(pending),  32'(5 - k));
            tick();
        end
        #1;
        chk("bp_done_pending",  32'(pending),  32'd0);
        chk("bp_done_regWrite", 32'(regWrite), 32'd0);

        // Bypass returns the youngest of two entries for the same register.
        rf_busy   = 1'b1;
        alu_valid = 1'b1;
        alu_reg   = 5'd7;
        alu_data  = 32'hA;
        tick();
        alu_data  = 32'hB;
        tick();
        alu_valid = 1'b0;
        byp_reg1  = 5'd7;
        byp_reg2  = 5'd8;
        #1;
        chk("byp_young_pending", 32'(pending),  32'd2);
        chk("byp_young_hit1",    32'(byp_hit1), 32'd1);
        chk("byp_young_data1",   byp_data1,     32'hB);
        chk("byp_young_hit2",    32'(byp_hit2), 32'd0);

        // Third entry via the load path, then reset with work outstanding.
        ld_valid = 1'b1;
        ld_reg   = 5'd12;
        ld_data  = 32'hC;
        #1;
        chk("mid_ld_ready", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        rf_busy  = 1'b0;
        #1;
        chk("mid_pending",  32'(pending),  32'd3);
        chk("mid_regWrite", 32'(regWrite), 32'd1);
        chk("mid_writeReg", 32'(writeReg), 32'd7);
        chk("mid_writeData", writeData,    32'hA);
        rst_n = 1'b0;
        #1;
        chk("mrst_regWrite", 32'(regWrite), 32'd0);
        chk("mrst_pending",  32'(pending),  32'd0);
        chk("mrst_writeReg", 32'(writeReg), 32'd0);
        chk("mrst_hit1",     32'(byp_hit1), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("post_rst%0d_regWrite", k), 32'(regWrite), 32'd0);
            chk($sformatf("post_rst%0d_pending", k),  32'(pending),  32'd0);
            tick();
        end
        // Grant history is cleared: first tie goes to the load again.
        alu_valid = 1'b1;
        alu_reg   = 5'd1;
        alu_data  = 32'h31;
        ld_valid  = 1'b1;
        ld_reg    = 5'd2;
        ld_data   = 32'h32;
        #1;
        chk("post_rst_tie_ld_ready",  32'(ld_ready),  32'd1);
        chk("post_rst_tie_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("post_rst_write_reg",  32'(writeReg), 32'd2);
        chk("post_rst_write_data", writeData,     32'h32);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
